hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage core. Detects load-use, redirect (branch/jump) and memory-wait
//  hazards and drives stall/flush/bubble/freeze controls to the PC, IF/ID, ID/EX and EX/MEM/WB registers.
//  Remembers redirects taken during an outstanding fetch and counts stall/flush cycles for debug.
// PARAMETERS
//  INIT_CYC  2   cycles the pipe is held flushed after reset release (>=1)
//  CNT_W     16  width of the saturating stall/flush counters
// PORTS
//  clk_i           in   1      clock, rising edge
//  rst_i           in   1      asynchronous reset, active high
//  IFID_rs_i       in   5      rs field of instruction in ID
//  IFID_rt_i       in   5      rt field of instruction in ID
//  IDEX_rt_i       in   5      destination rt of instruction in EX
//  IDEX_MemRead_i  in   1      instruction in EX is a load
//  brench_i        in   1      branch taken, resolved in ID
//  jump_i          in   1      jump in ID
//  imem_ready_i    in   1      instruction memory returns valid word this cycle
//  dmem_ready_i    in   1      data memory access completes (or none pending) this cycle
//  PC_write_o      out  1      1 = PC updates
//  Hazard_stall_o  out  1      1 = IF/ID holds its contents
//  flush_o         out  1      1 = IF/ID loads NOP (0)
//  IDEX_bubble_o   out  1      1 = ID/EX loads NOP control
//  pipe_freeze_o   out  1      1 = ID/EX, EX/MEM, MEM/WB hold
//  stall_cnt_o     out  CNT_W  cycles with Hazard_stall_o=1 outside INIT
//  flush_cnt_o     out  CNT_W  cycles with flush_o=1 outside INIT
// BEHAVIOUR
//  States INIT, RUN, REDIR_PEND; state and counters registered; control outputs combinational from state+inputs.
//  Reset: rst_i=1 forces INIT immediately (async), init counter loads 0, stall_cnt/flush_cnt = 0.
//  INIT outputs: PC_write=0, Hazard_stall=1, flush=1, IDEX_bubble=1, pipe_freeze=0; counters do not count.
//  INIT -> RUN after INIT_CYC rising edges with rst_i=0.
//  load_use = IDEX_MemRead_i & (IDEX_rt_i!=0) & (IDEX_rt_i==IFID_rs_i | IDEX_rt_i==IFID_rt_i).
//  RUN, first match wins (unlisted outputs 0):
//   1 dmem_ready_i=0 : pipe_freeze=1, Hazard_stall=1, PC_write=0; redirect/load_use ignored this cycle.
//   2 brench_i|jump_i: PC_write=1, flush=1; next REDIR_PEND if imem_ready_i=0, else RUN.
//   3 load_use       : PC_write=0, Hazard_stall=1, IDEX_bubble=1 (exactly one cycle per load).
//   4 imem_ready_i=0 : PC_write=0, Hazard_stall=1, IDEX_bubble=1.
//   5 otherwise      : PC_write=1.
//  REDIR_PEND (stale wrong-path fetch outstanding):
//   dmem_ready_i=0 -> same as RUN case 1, stay.
//   else flush=1, PC_write=0, Hazard_stall=0; brench_i/jump_i ignored; imem_ready_i=1 -> stale word
//   discarded, next RUN; else stay.
//  Simultaneous brench_i and jump_i: single redirect, one flush.
//  Counters: +1 per qualifying cycle, saturate at 2^CNT_W-1, no wrap; both may increment same cycle.
//  Hazard_stall=1 and flush=1 never both 1 outside INIT.
// TESTING
//  1 rst_i=1 mid-run -> outputs immediately PC_write=0,stall=1,flush=1,bubble=1, counters 0; release ->
//    2 cycles INIT, 3rd cycle PC_write=1.
//  2 RUN, MemRead=1, IDEX_rt=8, IFID_rs=8 -> one cycle stall=1,bubble=1,PC_write=0, stall_cnt 0->1;
//    repeat with IDEX_rt=0 -> no stall.
//  3 brench_i=1, imem_ready=1 -> one cycle flush=1, PC_write=1, flush_cnt+1, stays RUN.
//  4 jump_i=1, imem_ready=0 for 3 cycles then 1 -> REDIR_PEND, flush=1,PC_write=0 for 4 cycles
//    (flush_cnt +5 total), then RUN with PC_write=1.
//  5 dmem_ready=0 with brench_i=1 and load_use -> only freeze=1,stall=1; dmem_ready=1 next -> flush cycle.
//  6 CNT_W=4, 20 consecutive imem_ready=0 cycles -> stall_cnt_o=15 (saturated); async reset in
//    REDIR_PEND -> INIT, counters 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Pipeline sequencer for the 5-stage core. Detects load-use,
//             redirect (branch/jump) and memory-wait hazards, drives the
//             PC / IF-ID / ID-EX / back-end hold and flush controls, tracks
//             redirects taken while a fetch is still outstanding, and keeps
//             saturating stall/flush cycle counters for debug.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
  parameter int INIT_CYC = 2,   // cycles the pipe stays flushed after reset (>=1)
  parameter int CNT_W    = 16   // width of the debug counters
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_rs_i,
  input  logic [4:0]       IFID_rt_i,
  input  logic [4:0]       IDEX_rt_i,
  input  logic             IDEX_MemRead_i,
  input  logic             brench_i,
  input  logic             jump_i,
  input  logic             imem_ready_i,
  input  logic             dmem_ready_i,
  output logic             PC_write_o,
  output logic             Hazard_stall_o,
  output logic             flush_o,
  output logic             IDEX_bubble_o,
  output logic             pipe_freeze_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int                c_init_w    = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam logic [c_init_w-1:0] c_init_last = c_init_w'(INIT_CYC - 1);
  localparam logic [CNT_W-1:0]  c_cnt_max   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_INIT       = 2'd0,
    ST_RUN        = 2'd1,
    ST_REDIR_PEND = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_init_w-1:0] r_init_cnt;
  logic                r_lu_stalled;   // a load-use stall was issued for the load now leaving EX
  logic                w_lu_taken;
  logic                w_load_use;
  logic                w_redirect;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  // The cycle after a load-use stall ID/EX holds a bubble, so a repeated match
  // on held inputs is not a new load and must not stall again.
  assign w_load_use = IDEX_MemRead_i & (IDEX_rt_i != 5'd0) &
                      ((IDEX_rt_i == IFID_rs_i) | (IDEX_rt_i == IFID_rt_i)) &
                      ~r_lu_stalled;
  // Branch and jump together are one redirect.
  assign w_redirect = brench_i | jump_i;

  // State register, async reset into INIT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  // Counts the post-reset hold cycles; parked at zero outside INIT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                           r_init_cnt <= '0;
    else if (r_state == ST_INIT && r_init_cnt != c_init_last) r_init_cnt <= r_init_cnt + 1'b1;
    else if (r_state != ST_INIT)                         r_init_cnt <= '0;
  end

  // Remembers that the current load already got its stall; survives freezes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              r_lu_stalled <= 1'b0;
    else if (w_lu_taken)    r_lu_stalled <= 1'b1;
    else if (!pipe_freeze_o) r_lu_stalled <= 1'b0;
  end

  // Next-state and control outputs, priority ordered within each state.
  always_comb begin
    w_state_nxt    = r_state;
    w_lu_taken     = 1'b0;
    PC_write_o     = 1'b0;
    Hazard_stall_o = 1'b0;
    flush_o        = 1'b0;
    IDEX_bubble_o  = 1'b0;
    pipe_freeze_o  = 1'b0;
    case (r_state)
      ST_INIT: begin
        Hazard_stall_o = 1'b1;
        flush_o        = 1'b1;
        IDEX_bubble_o  = 1'b1;
        if (r_init_cnt == c_init_last) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!dmem_ready_i) begin
          pipe_freeze_o  = 1'b1;
          Hazard_stall_o = 1'b1;
        end else if (w_redirect) begin
          PC_write_o = 1'b1;
          flush_o    = 1'b1;
          // Wrong-path fetch still in flight: its word must be dropped later.
          if (!imem_ready_i) w_state_nxt = ST_REDIR_PEND;
        end else if (w_load_use) begin
          Hazard_stall_o = 1'b1;
          IDEX_bubble_o  = 1'b1;
          w_lu_taken     = 1'b1;
        end else if (!imem_ready_i) begin
          Hazard_stall_o = 1'b1;
          IDEX_bubble_o  = 1'b1;
        end else begin
          PC_write_o = 1'b1;
        end
      end
      ST_REDIR_PEND: begin
        if (!dmem_ready_i) begin
          pipe_freeze_o  = 1'b1;
          Hazard_stall_o = 1'b1;
        end else begin
          flush_o = 1'b1;
          if (imem_ready_i) w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Saturating debug counters, idle during INIT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (r_state != ST_INIT) begin
      if (Hazard_stall_o && r_stall_cnt != c_cnt_max) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush_o && r_flush_cnt != c_cnt_max)        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Self-checking bench for hazard_ctrl (default and 4-bit counters).
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] rs, rt, idex_rt;
  logic       memread, br, jmp, imem, dmem;

  logic        pc_a, st_a, fl_a, bb_a, fz_a;
  logic [15:0] stc_a, flc_a;
  logic        pc_b, st_b, fl_b, bb_b, fz_b;
  logic [3:0]  stc_b, flc_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] e_st, e_fl;
  logic [3:0]  e_st4, e_fl4;

  hazard_ctrl #(.INIT_CYC(2), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .IFID_rs_i(rs), .IFID_rt_i(rt), .IDEX_rt_i(idex_rt), .IDEX_MemRead_i(memread),
    .brench_i(br), .jump_i(jmp), .imem_ready_i(imem), .dmem_ready_i(dmem),
    .PC_write_o(pc_a), .Hazard_stall_o(st_a), .flush_o(fl_a),
    .IDEX_bubble_o(bb_a), .pipe_freeze_o(fz_a),
    .stall_cnt_o(stc_a), .flush_cnt_o(flc_a)
  );

  hazard_ctrl #(.INIT_CYC(2), .CNT_W(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst),
    .IFID_rs_i(rs), .IFID_rt_i(rt), .IDEX_rt_i(idex_rt), .IDEX_MemRead_i(memread),
    .brench_i(br), .jump_i(jmp), .imem_ready_i(imem), .dmem_ready_i(dmem),
    .PC_write_o(pc_b), .Hazard_stall_o(st_b), .flush_o(fl_b),
    .IDEX_bubble_o(bb_b), .pipe_freeze_o(fz_b),
    .stall_cnt_o(stc_b), .flush_cnt_o(flc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs are packed as {PC_write, stall, flush, bubble, freeze}.
  localparam logic [4:0] c_O_INIT  = 5'b01110;
  localparam logic [4:0] c_O_RUN   = 5'b10000;
  localparam logic [4:0] c_O_REDIR = 5'b10100;
  localparam logic [4:0] c_O_STALL = 5'b01010;
  localparam logic [4:0] c_O_FRZ   = 5'b01001;
  localparam logic [4:0] c_O_PEND  = 5'b00100;

  typedef struct {
    logic [4:0] rs, rt, idex_rt;
    logic       memread, br, jmp, imem, dmem;
    logic [4:0] exp_o;
    logic       st_inc, fl_inc;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic [4:0] a_rs, a_rt, a_irt,
                              input logic a_mr, a_br, a_j, a_im, a_dm,
                              input logic [4:0] a_o, input logic a_si, a_fi);
    vec_t v;
    v.rs = a_rs; v.rt = a_rt; v.idex_rt = a_irt;
    v.memread = a_mr; v.br = a_br; v.jmp = a_j; v.imem = a_im; v.dmem = a_dm;
    v.exp_o = a_o; v.st_inc = a_si; v.fl_inc = a_fi;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_default();
    rs = 5'd1; rt = 5'd2; idex_rt = 5'd3; memread = 1'b0;
    br = 1'b0; jmp = 1'b0; imem = 1'b1; dmem = 1'b1;
  endtask

  task automatic chk_out(input string name, input logic [4:0] exp);
    logic [9:0] act;
    act = {pc_a, st_a, fl_a, bb_a, fz_a, pc_b, st_b, fl_b, bb_b, fz_b};
    n_tests++;
    if (act !== {exp, exp}) begin
      n_fail++;
      $display("FAIL %s: outputs {pc,stall,flush,bubble,freeze}x2 got %b required %b", name, act, {exp, exp});
    end
  endtask

  task automatic chk_cnt(input string name);
    n_tests++;
    if ({stc_a, flc_a} !== {e_st, e_fl}) begin
      n_fail++;
      $display("FAIL %s: cnt16 stall/flush got %0d/%0d required %0d/%0d", name, stc_a, flc_a, e_st, e_fl);
    end
    n_tests++;
    if ({stc_b, flc_b} !== {e_st4, e_fl4}) begin
      n_fail++;
      $display("FAIL %s: cnt4 stall/flush got %0d/%0d required %0d/%0d", name, stc_b, flc_b, e_st4, e_fl4);
    end
  endtask

  task automatic bump(input logic si, input logic fi);
    if (si && e_st  != 16'hFFFF) e_st  = e_st  + 1'b1;
    if (fi && e_fl  != 16'hFFFF) e_fl  = e_fl  + 1'b1;
    if (si && e_st4 != 4'hF)     e_st4 = e_st4 + 1'b1;
    if (fi && e_fl4 != 4'hF)     e_fl4 = e_fl4 + 1'b1;
  endtask

  // One cycle: inputs already set; check outputs, clock, check counters.
  task automatic cycle(input string name, input logic [4:0] exp, input logic si, input logic fi);
    #2;
    chk_out(name, exp);
    tick();
    bump(si, fi);
    chk_cnt({name, "_cnt"});
  endtask

  // Called with rst already high, mid-cycle: checks async effect and release.
  task automatic init_seq(input string name);
    #1;
    e_st = '0; e_fl = '0; e_st4 = '0; e_fl4 = '0;
    chk_out({name, "_rst"}, c_O_INIT);
    chk_cnt({name, "_rst"});
    set_default();
    tick();
    rst = 1'b0;
    #2; chk_out({name, "_init1"}, c_O_INIT);
    tick();
    #2; chk_out({name, "_init2"}, c_O_INIT);
    tick();
    cycle({name, "_run"}, c_O_RUN, 1'b0, 1'b0);
  endtask

  initial begin
    //              rs    rt    irt  mr  br  j   im  dm  out        si  fi
    vecs[0]  = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 1, c_O_RUN,   0, 0);
    vecs[1]  = mk(5'd8, 5'd2, 5'd8, 1, 0, 0, 1, 1, c_O_STALL, 1, 0);
    vecs[2]  = mk(5'd8, 5'd2, 5'd8, 1, 0, 0, 1, 1, c_O_RUN,   0, 0);
    vecs[3]  = mk(5'd1, 5'd5, 5'd5, 1, 0, 0, 1, 1, c_O_STALL, 1, 0);
    vecs[4]  = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 1, c_O_RUN,   0, 0);
    vecs[5]  = mk(5'd0, 5'd2, 5'd0, 1, 0, 0, 1, 1, c_O_RUN,   0, 0);
    vecs[6]  = mk(5'd8, 5'd2, 5'd8, 0, 0, 0, 1, 1, c_O_RUN,   0, 0);
    vecs[7]  = mk(5'd1, 5'd2, 5'd3, 0, 1, 0, 1, 1, c_O_REDIR, 0, 1);
    vecs[8]  = mk(5'd1, 5'd2, 5'd3, 0, 0, 1, 1, 1, c_O_REDIR, 0, 1);
    vecs[9]  = mk(5'd1, 5'd2, 5'd3, 0, 1, 1, 1, 1, c_O_REDIR, 0, 1);
    vecs[10] = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, c_O_STALL, 1, 0);
    vecs[11] = mk(5'd8, 5'd2, 5'd8, 1, 1, 0, 1, 0, c_O_FRZ,   1, 0);
    vecs[12] = mk(5'd8, 5'd2, 5'd8, 1, 1, 0, 1, 1, c_O_REDIR, 0, 1);
    vecs[13] = mk(5'd8, 5'd2, 5'd8, 1, 0, 0, 0, 1, c_O_STALL, 1, 0);
    vecs[14] = mk(5'd8, 5'd2, 5'd8, 1, 0, 0, 0, 1, c_O_STALL, 1, 0);
    vecs[15] = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 1, c_O_RUN,   0, 0);

    set_default();
    rst = 1'b1;
    init_seq("por");

    // RUN-state vector table
    for (int i = 0; i < 16; i++) begin
      rs = vecs[i].rs; rt = vecs[i].rt; idex_rt = vecs[i].idex_rt;
      memread = vecs[i].memread; br = vecs[i].br; jmp = vecs[i].jmp;
      imem = vecs[i].imem; dmem = vecs[i].dmem;
      cycle($sformatf("vec%0d", i), vecs[i].exp_o, vecs[i].st_inc, vecs[i].fl_inc);
    end

    // Jump with fetch outstanding: 1 redirect + 4 pending flush cycles
    set_default(); jmp = 1'b1; imem = 1'b0;
    cycle("jmp_redir", c_O_REDIR, 1'b0, 1'b1);
    jmp = 1'b0;
    for (int i = 0; i < 3; i++) cycle($sformatf("pend%0d", i), c_O_PEND, 1'b0, 1'b1);
    imem = 1'b1; br = 1'b1;
    cycle("pend_last", c_O_PEND, 1'b0, 1'b1);
    set_default();
    cycle("pend_exit", c_O_RUN, 1'b0, 1'b0);

    // Memory wait while a redirect is pending freezes and stays pending
    br = 1'b1; imem = 1'b0;
    cycle("br_redir", c_O_REDIR, 1'b0, 1'b1);
    br = 1'b0; dmem = 1'b0; imem = 1'b1;
    cycle("pend_frz", c_O_FRZ, 1'b1, 1'b0);
    dmem = 1'b1;
    cycle("pend_drop", c_O_PEND, 1'b0, 1'b1);
    set_default();
    cycle("pend_run", c_O_RUN, 1'b0, 1'b0);

    // Mid-run asynchronous reset
    #2; rst = 1'b1;
    init_seq("midrst");

    // 20 fetch-wait cycles saturate the 4-bit stall counter
    imem = 1'b0;
    for (int i = 0; i < 20; i++) cycle($sformatf("iwait%0d", i), c_O_STALL, 1'b1, 1'b0);
    n_tests++;
    if (stc_b !== 4'd15) begin
      n_fail++;
      $display("FAIL sat4: stall_cnt got %0d required 15", stc_b);
    end

    // Reset while in REDIR_PEND
    set_default(); jmp = 1'b1; imem = 1'b0;
    cycle("jmp_redir2", c_O_REDIR, 1'b0, 1'b1);
    jmp = 1'b0;
    cycle("pend_pre_rst", c_O_PEND, 1'b0, 1'b1);
    rst = 1'b1;
    init_seq("pendrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
